// File: rtl/audio_sampler_top_if.sv
// -----------------------------------------------------------------------------
// audio_sampler_top_if
//   Bundle of the audio codec I2S-side pins of the Zybo audio sampler.
//   master : the sampler (drives mclk, playback data and mute)
//   slave  : the codec / board (drives bit clock, LR clock, record pins)
// Signals
//   ac_mclk   codec master clock                (master -> slave)
//   ac_bclk   I2S bit clock                     (slave  -> master)
//   ac_pblrc  playback LR clock, 0 = left       (slave  -> master)
//   ac_pbdat  playback serial data              (master -> slave)
//   ac_recdat record data, unused by the master (slave  -> master)
//   ac_reclrc record LR clock, unused           (slave  -> master)
//   ac_muten  codec mute, active low            (master -> slave)
// -----------------------------------------------------------------------------
interface audio_sampler_top_if;
    logic ac_mclk;
    logic ac_bclk;
    logic ac_pblrc;
    logic ac_pbdat;
    logic ac_recdat;
    logic ac_reclrc;
    logic ac_muten;

    modport master (
        output ac_mclk, ac_pbdat, ac_muten,
        input  ac_bclk, ac_pblrc, ac_recdat, ac_reclrc
    );

    modport slave (
        input  ac_mclk, ac_pbdat, ac_muten,
        output ac_bclk, ac_pblrc, ac_recdat, ac_reclrc
    );
endinterface

// File: rtl/audio_sampler_top.sv
// -----------------------------------------------------------------------------
// audio_sampler_top
//   Zybo audio sampler. Initialises the codec over I2C from a fixed 10-word
//   register table, generates the codec master clock and streams a 24-bit
//   square-wave tone (amplitude from sw) as I2S playback data. BCLK/PBLRC come
//   back from the board; the block is the I2S transmitter in codec-slave mode.
// Ports
//   s00_axi_aclk    sole clock
//   s00_axi_aresetn synchronous active-low reset
//   sw[3:0]         tone amplitude select
//   btn[3:0]        btn[0] rising edge restarts codec init
//   led[3:0]        [0] init done, [1] I2C busy, [2] NACK seen, [3] tone phase
//   codec           I2S pin bundle (mclk/pbdat/muten out, bclk/pblrc in)
//   i2c_scl/sda     open-drain I2C, driven 0 or released to Z
// -----------------------------------------------------------------------------
module audio_sampler_top #(
    parameter int         MCLK_DIV    = 10,
    parameter int         I2C_DIV     = 312,
    parameter logic [6:0] CODEC_ADDR  = 7'h1A,
    parameter int         TONE_FRAMES = 50
) (
    input  logic                       s00_axi_aclk,
    input  logic                       s00_axi_aresetn,
    input  logic [3:0]                 sw,
    input  logic [3:0]                 btn,
    output logic [3:0]                 led,
    audio_sampler_top_if.master        codec,
    inout  wire                        i2c_scl,
    inout  wire                        i2c_sda
);

    localparam int MCLK_HALF = MCLK_DIV / 2;
    localparam int MW        = $clog2(MCLK_HALF + 1);
    localparam int QW        = $clog2(I2C_DIV + 1);
    localparam int TW        = $clog2(TONE_FRAMES + 1);
    localparam logic [3:0] NUM_WORDS = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_HI, S_ACK2,
        S_LO, S_ACK3, S_STOP, S_GAP, S_DONE
    } i2c_state_t;

    logic clk;
    logic rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    logic unused_inputs;
    assign unused_inputs = ^{btn[3:1], codec.ac_recdat, codec.ac_reclrc};

    // NOTE: the init table is a constant ROM decoded from the index, so there is
    // no storage to reset; only the index register needs a reset value.
    function automatic logic [15:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd0:    init_word = 16'h1E00;
            4'd1:    init_word = 16'h0C10;
            4'd2:    init_word = 16'h0017;
            4'd3:    init_word = 16'h0217;
            4'd4:    init_word = 16'h0812;
            4'd5:    init_word = 16'h0A00;
            4'd6:    init_word = 16'h0E0A;
            4'd7:    init_word = 16'h1000;
            4'd8:    init_word = 16'h1201;
            4'd9:    init_word = 16'h0C00;
            default: init_word = 16'h0000;
        endcase
    endfunction

    // ------------------------------------------------------------------ MCLK
    logic [MW-1:0] mclk_cnt;

    // NOTE: all clocked state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mclk_cnt      <= '0;
            codec.ac_mclk <= 1'b0;
        end else if (mclk_cnt == MW'(MCLK_HALF - 1)) begin
            mclk_cnt      <= '0;
            codec.ac_mclk <= ~codec.ac_mclk;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    // ------------------------------------------------- input synchronisers
    logic [2:0] btn_s;
    logic [1:0] sda_s;
    logic [2:0] bclk_s;
    logic [1:0] lrc_s;
    logic       btn_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s  <= '0;
            sda_s  <= 2'b11;
            bclk_s <= '0;
            lrc_s  <= '0;
        end else begin
            btn_s  <= {btn_s[1:0], btn[0]};
            sda_s  <= {sda_s[0], i2c_sda};
            bclk_s <= {bclk_s[1:0], codec.ac_bclk};
            lrc_s  <= {lrc_s[0], codec.ac_pblrc};
        end
    end

    assign btn_rise = btn_s[1] & ~btn_s[2];

    // --------------------------------------------------------- I2C init FSM
    i2c_state_t    state, state_next;
    logic [QW-1:0] q_div;
    logic [2:0]    qcnt;
    logic [2:0]    bit_idx;
    logic [3:0]    word_idx;
    logic          ack_bad;
    logic          nack_flag;
    logic          busy_flag;
    logic          done_flag;
    logic          tick;
    logic          step_end;
    logic          byte_end;
    logic          is_ack;
    logic          is_byte;
    logic          scl_low_d, sda_low_d;
    logic          scl_low_q, sda_low_q;
    logic [7:0]    tx_byte;

    assign tick     = (q_div == QW'(I2C_DIV - 1));
    // GAP lasts 8 quarters, every other step is one 4-quarter bit period.
    assign step_end = tick && (qcnt == ((state == S_GAP) ? 3'd7 : 3'd3));
    assign byte_end = step_end && (bit_idx == 3'd7);
    assign is_ack   = (state == S_ACK1) || (state == S_ACK2) || (state == S_ACK3);
    assign is_byte  = (state == S_ADDR) || (state == S_HI) || (state == S_LO);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (btn_rise) begin
            state_next = S_GAP;
        end else begin
            case (state)
                S_IDLE:  state_next = S_START;
                S_START: if (step_end) state_next = S_ADDR;
                S_ADDR:  if (byte_end) state_next = S_ACK1;
                S_ACK1:  if (step_end) state_next = ack_bad ? S_STOP : S_HI;
                S_HI:    if (byte_end) state_next = S_ACK2;
                S_ACK2:  if (step_end) state_next = ack_bad ? S_STOP : S_LO;
                S_LO:    if (byte_end) state_next = S_ACK3;
                S_ACK3:  if (step_end) state_next = S_STOP;
                S_STOP:  if (step_end) state_next = S_GAP;
                S_GAP:   if (step_end) state_next = (word_idx == NUM_WORDS) ? S_DONE : S_START;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_ADDR:  tx_byte = {CODEC_ADDR, 1'b0};
            S_HI:    tx_byte = init_word(word_idx)[15:8];
            S_LO:    tx_byte = init_word(word_idx)[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // Line drive per quarter: SCL is low in quarters 0 and 3 of a bit, high in
    // 1 and 2, so data moves only while SCL is low.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state)
            S_START: begin
                scl_low_d = (qcnt == 3'd3);
                sda_low_d = (qcnt >= 3'd2);
            end
            S_ADDR, S_HI, S_LO: begin
                scl_low_d = (qcnt == 3'd0) || (qcnt == 3'd3);
                sda_low_d = ~tx_byte[3'd7 - bit_idx];
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                scl_low_d = (qcnt == 3'd0) || (qcnt == 3'd3);
            end
            S_STOP: begin
                scl_low_d = (qcnt == 3'd0);
                sda_low_d = (qcnt <= 3'd1);
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_div     <= '0;
            qcnt      <= '0;
            bit_idx   <= '0;
            word_idx  <= '0;
            ack_bad   <= 1'b0;
            nack_flag <= 1'b0;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            if (btn_rise) begin
                q_div     <= '0;
                qcnt      <= '0;
                bit_idx   <= '0;
                word_idx  <= '0;
                nack_flag <= 1'b0;
                busy_flag <= 1'b0;
                done_flag <= 1'b0;
            end else begin
                if (state == S_IDLE || state == S_DONE) q_div <= '0;
                else if (tick)                          q_div <= '0;
                else                                    q_div <= q_div + 1'b1;

                if (tick) qcnt <= step_end ? 3'd0 : qcnt + 3'd1;

                if (step_end && is_byte) bit_idx <= bit_idx + 3'd1;

                // ACK sampled at the SCL-high midpoint (end of quarter 1).
                if (tick && is_ack && qcnt == 3'd1) begin
                    ack_bad   <= sda_s[1];
                    nack_flag <= nack_flag | sda_s[1];
                end

                if (state == S_STOP && step_end) word_idx <= word_idx + 4'd1;
                if (state == S_START)            busy_flag <= 1'b1;

                if (state == S_GAP && step_end && word_idx == NUM_WORDS) begin
                    busy_flag <= 1'b0;
                    done_flag <= 1'b1;
                end
            end
        end
    end

    assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    // ---------------------------------------------------------- I2S transmit
    logic        bclk_fall;
    logic        lrc_now;
    logic        lrc_prev;
    logic        lrc_rise;
    logic [23:0] amp;
    logic [23:0] sample;
    logic [23:0] shreg;
    logic [4:0]  bit_left;
    logic        pbdat_q;
    logic [TW-1:0] frame_cnt;
    logic        phase;

    // bclk and lrc pass through equal-depth synchronisers, so lrc_now is the
    // LR level seen at the same instant as the detected bclk fall.
    assign bclk_fall = bclk_s[2] & ~bclk_s[1];
    assign lrc_now   = lrc_s[1];
    assign lrc_rise  = bclk_fall & lrc_now & ~lrc_prev;
    assign amp       = {sw, 20'h0};
    assign sample    = !done_flag ? 24'h0 : (phase ? (24'h0 - amp) : amp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lrc_prev <= 1'b0;
            shreg    <= '0;
            bit_left <= '0;
            pbdat_q  <= 1'b0;
        end else if (bclk_fall) begin
            lrc_prev <= lrc_now;
            if (lrc_now != lrc_prev) begin
                // Load on the change; the MSB leaves on the following fall.
                shreg    <= sample;
                bit_left <= 5'd24;
                pbdat_q  <= 1'b0;
            end else if (bit_left != 5'd0) begin
                pbdat_q  <= shreg[23];
                shreg    <= {shreg[22:0], 1'b0};
                bit_left <= bit_left - 5'd1;
            end else begin
                pbdat_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (lrc_rise) begin
            if (frame_cnt == TW'(TONE_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign codec.ac_pbdat = pbdat_q & done_flag;
    assign codec.ac_muten = done_flag;
    assign led            = {phase, nack_flag, busy_flag, done_flag};

endmodule

// File: tb/tb_audio_sampler_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_audio_sampler_top
//   Directed bench for audio_sampler_top: a bus monitor decodes I2C bytes and
//   STOPs, an optional slave model ACKs each byte, and a loopback of mclk onto
//   bclk with a 64-bit LR divider exercises the I2S transmitter.
// -----------------------------------------------------------------------------
module tb_audio_sampler_top;

    localparam int MCLK_DIV    = 10;
    localparam int I2C_DIV     = 4;
    localparam int TONE_FRAMES = 2;
    localparam logic [15:0] TBL [10] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0812,
                                         16'h0A00, 16'h0E0A, 16'h1000, 16'h1201, 16'h0C00};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'h0;
    logic [3:0] btn   = 4'h0;
    logic [3:0] led;
    wire        i2c_scl;
    wire        i2c_sda;

    pullup pu_scl (i2c_scl);
    pullup pu_sda (i2c_sda);

    logic tb_sda_low = 1'b0;
    assign i2c_sda = tb_sda_low ? 1'b0 : 1'bz;

    audio_sampler_top_if codec ();

    logic       loop_en = 1'b0;
    logic [5:0] lrc_cnt = 6'd0;
    assign codec.ac_bclk   = loop_en ? codec.ac_mclk : 1'b0;
    assign codec.ac_pblrc  = &lrc_cnt;
    assign codec.ac_recdat = 1'b0;
    assign codec.ac_reclrc = 1'b0;

    always @(negedge codec.ac_bclk) lrc_cnt <= lrc_cnt + 6'd1;

    audio_sampler_top #(
        .MCLK_DIV    (MCLK_DIV),
        .I2C_DIV     (I2C_DIV),
        .CODEC_ADDR  (7'h1A),
        .TONE_FRAMES (TONE_FRAMES)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .sw              (sw),
        .btn             (btn),
        .led             (led),
        .codec           (codec),
        .i2c_scl         (i2c_scl),
        .i2c_sda         (i2c_sda)
    );

    always #4 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------- I2C monitor
    logic       mon_en   = 1'b0;
    logic       ack_mode = 1'b0;
    logic       hold0    = 1'b0;
    int         bitcnt   = 0;
    int         stops    = 0;
    int         starts   = 0;
    int         first_scl_starts = -1;
    logic [7:0] sh       = 8'h00;
    logic [7:0] bytes [$];

    always @(negedge i2c_sda) if (mon_en && i2c_scl === 1'b1) begin
        starts++;
        bitcnt = 0;
    end

    always @(posedge i2c_sda) if (mon_en && i2c_scl === 1'b1) begin
        stops++;
        bitcnt = 0;
    end

    always @(posedge i2c_scl) if (mon_en) begin
        if (bitcnt < 8) sh = {sh[6:0], i2c_sda === 1'b1};
        bitcnt++;
        if (bitcnt == 9) begin
            bytes.push_back(sh);
            bitcnt = 0;
        end
    end

    always @(negedge i2c_scl) if (mon_en) begin
        if (first_scl_starts < 0) first_scl_starts = starts;
        tb_sda_low = hold0 || (ack_mode && bitcnt == 8);
    end

    int n_rise = 0;
    always @(posedge codec.ac_pblrc) n_rise++;

    // ------------------------------------------------------------- helpers
    function automatic logic pick(input int sel);
        case (sel)
            0:       pick = codec.ac_bclk;
            1:       pick = codec.ac_pblrc;
            default: pick = i2c_scl;
        endcase
    endfunction

    task automatic wait_fall(input int sel, input int budget, output bit ok);
        logic prev, now;
        prev = pick(sel);
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            now = pick(sel);
            if (prev === 1'b1 && now === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = now;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20000 && led[0] !== 1'b1; i++) @(posedge clk);
        #1;
        check(tag, led[0], 1);
    endtask

    task automatic pulse_btn();
        btn[0] = 1'b1;
        repeat (4) @(posedge clk);
        btn[0] = 1'b0;
    endtask

    task automatic clear_monitor();
        bytes.delete();
        stops  = 0;
        starts = 0;
        bitcnt = 0;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        time        t0, t1, t2;
        bit         ok;
        logic [23:0] word;
        logic [3:0]  tail;
        logic        any_hi;
        int          exp_phase;

        repeat (25) @(posedge clk);
        #1;
        check("rst_led",   led, 4'h0);
        check("rst_mclk",  codec.ac_mclk, 0);
        check("rst_pbdat", codec.ac_pbdat, 0);
        check("rst_muten", codec.ac_muten, 0);
        check("rst_scl",   i2c_scl, 1);
        check("rst_sda",   i2c_sda, 1);

        ack_mode = 1'b1;
        mon_en   = 1'b1;
        rst_n    = 1'b1;

        @(posedge codec.ac_mclk); t0 = $time;
        @(negedge codec.ac_mclk); t1 = $time;
        @(posedge codec.ac_mclk); t2 = $time;
        check("mclk_high_ns",   32'(t1 - t0), 40);
        check("mclk_period_ns", 32'(t2 - t0), 80);

        // Run into word 3 with an ACKing slave, then restart with btn[0].
        for (int i = 0; i < 20000 && bytes.size() < 10; i++) @(posedge clk);
        check("bytes_before_abort", bytes.size(), 10);
        check("first_scl_after_start", first_scl_starts, 1);
        check("w0_addr", bytes[0], 8'h34);
        check("w0_hi",   bytes[1], 8'h1E);
        check("w0_lo",   bytes[2], 8'h00);
        wait_fall(2, 200, ok);
        wait_fall(2, 200, ok);
        #1;
        check("busy_mid_init", led[1:0], 2'b10);
        pulse_btn();
        repeat (I2C_DIV) @(posedge clk);
        #1;
        check("abort_scl_released", i2c_scl, 1);
        check("abort_sda_released", i2c_sda, 1);
        check("abort_leds_cleared", led[2:0], 3'b000);
        check("abort_muten",        codec.ac_muten, 0);
        clear_monitor();

        wait_done("reinit_done");
        check("reinit_bytes", bytes.size(), 30);
        if (bytes.size() == 30) begin
            for (int w = 0; w < 10; w++) begin
                check($sformatf("w%0d_addr", w), bytes[3*w],   8'h34);
                check($sformatf("w%0d_hi", w),   bytes[3*w+1], {24'h0, TBL[w][15:8]});
                check($sformatf("w%0d_lo", w),   bytes[3*w+2], {24'h0, TBL[w][7:0]});
            end
        end
        check("ack_stops", stops, 10);
        check("ack_led",   led[2:0], 3'b001);
        check("ack_muten", codec.ac_muten, 1);

        // No slave: every address byte NACKs, each word still ends in STOP.
        ack_mode = 1'b0;
        pulse_btn();
        repeat (6) @(posedge clk);
        clear_monitor();
        wait_done("nack_done");
        check("nack_led2",  led[2], 1);
        check("nack_busy",  led[1], 0);
        check("nack_stops", stops, 10);
        check("nack_bytes", bytes.size(), 10);
        for (int i = 0; i < bytes.size(); i++) check("nack_addr", bytes[i], 8'h34);

        // SDA held low externally: always ACK.
        mon_en     = 1'b0;
        hold0      = 1'b1;
        tb_sda_low = 1'b1;
        pulse_btn();
        repeat (6) @(posedge clk);
        #1;
        check("hold0_led_after_restart", led[2:0], 3'b000);
        wait_done("hold0_done");
        check("hold0_led2", led[2], 0);
        hold0      = 1'b0;
        tb_sda_low = 1'b0;

        // No bit clock yet: playback data stays low.
        sw     = 4'hF;
        any_hi = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            any_hi |= (codec.ac_pbdat !== 1'b0);
        end
        check("no_bclk_pbdat", any_hi, 0);

        // Loopback: left channel sample follows each LR fall.
        loop_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_fall(1, 2000, ok);
            check("lrc_fall_seen", ok, 1);
            exp_phase = (n_rise / TONE_FRAMES) % 2;
            word = '0;
            tail = '0;
            for (int b = 0; b < 28; b++) begin
                wait_fall(0, 50, ok);
                repeat (4) @(posedge clk);
                #1;
                if (b < 24) word = {word[22:0], codec.ac_pbdat};
                else        tail = {tail[2:0], codec.ac_pbdat};
            end
            check($sformatf("led3_frame%0d", f), led[3], exp_phase);
            check($sformatf("sample_frame%0d", f), word, exp_phase ? 24'h100000 : 24'hF00000);
            check($sformatf("tail_frame%0d", f), tail, 4'h0);
        end

        // Silence with sw = 0 over a whole frame.
        sw = 4'h0;
        wait_fall(1, 2000, ok);
        any_hi = 1'b0;
        for (int i = 0; i < 64 * MCLK_DIV; i++) begin
            @(posedge clk);
            any_hi |= (codec.ac_pbdat !== 1'b0);
        end
        check("sw0_silence", any_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
